// File: rtl/wb_regfile.sv
// wb_regfile -- writeback-stage register file for a 16-bit pipeline.
//
// The writeback mux (resultW) picks the value the MEM/WB stage retires. A
// write commits it on the rising edge. Register 0 always reads as zero, and
// writes to it are dropped and not counted. Both decode read ports are
// combinational and write-first: a write committing in the current cycle is
// forwarded to a matching read port. The debug port shows only stored
// contents, with no forwarding. wr_count counts committed writes and wraps
// silently.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high; clears every register and wr_count
//   regWrite_in   writeback enable
//   resultSrc_in  00 ALU, 01 memory read data, 10 PC+2, 11 reserved (zero)
//   pc_plus2_in   link/return address
//   rd_in         destination register index
//   aluRes_in     ALU result
//   readData_in   data-memory read data
//   ra1, ra2      decode read addresses
//   rd1, rd2      decode read data (forwarded, write-first)
//   resultW       selected writeback value, to the forwarding network
//   dbg_addr      debug read address
//   dbg_data      debug read data (stored value only)
//   wr_count      number of committed register writes
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite_in,
  input  logic [1:0]        resultSrc_in,
  input  logic [DATA_W-1:0] pc_plus2_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic [DATA_W-1:0] aluRes_in,
  input  logic [DATA_W-1:0] readData_in,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] resultW,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;

  // Register 0 is hard-wired to zero on every read port. Otherwise, a write
  // committing this cycle to the same index wins over the stored value.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    if (ra == '0)
      return '0;
    else if (wr_en && (wr_addr == ra))
      return wr_data;
    else
      return stored;
  endfunction

  // Writeback mux. It stays purely combinational and ignores reset.
  always_comb begin
    resultW = '0;
    case (resultSrc_in)
      2'b00:   resultW = aluRes_in;
      2'b01:   resultW = readData_in;
      2'b10:   resultW = pc_plus2_in;
      default: resultW = '0;
    endcase
  end

  // Reset also gates commit. This drops the in-flight write and disables
  // forwarding while reset is held.
  assign commit = regWrite_in && (rd_in != '0) && !reset;

  always_comb begin
    rd1 = read_port(ra1, regs[ra1], commit, rd_in, resultW);
    rd2 = read_port(ra2, regs[ra2], commit, rd_in, resultW);
  end

  // The debug view never forwards, so data appears the cycle after commit.
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  // ---- commit edge ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      wr_count <= '0;
    end else if (commit) begin
      regs[rd_in] <= resultW;
      wr_count    <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite_in;
  logic [1:0]  resultSrc_in;
  logic [15:0] pc_plus2_in;
  logic [3:0]  rd_in;
  logic [15:0] aluRes_in;
  logic [15:0] readData_in;
  logic [3:0]  ra1, ra2, dbg_addr;
  logic [15:0] rd1, rd2, resultW, dbg_data, wr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .regWrite_in(regWrite_in),
    .resultSrc_in(resultSrc_in),
    .pc_plus2_in(pc_plus2_in),
    .rd_in(rd_in),
    .aluRes_in(aluRes_in),
    .readData_in(readData_in),
    .ra1(ra1),
    .ra2(ra2),
    .rd1(rd1),
    .rd2(rd2),
    .resultW(resultW),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .wr_count(wr_count)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; regWrite_in = 1'b0; resultSrc_in = 2'b00;
    pc_plus2_in = 16'h0; rd_in = 4'd0; aluRes_in = 16'h0; readData_in = 16'h0;
    ra1 = 4'd0; ra2 = 4'd0; dbg_addr = 4'd0;

    // Hold reset for two cycles, then read every address through every port.
    step(); step();
    reset = 1'b0;
    #1;
    check("reset_wr_count", wr_count, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i); ra2 = 4'(15 - i); dbg_addr = 4'(i);
      #1;
      check($sformatf("reset_rd1_%0d", i), rd1, 16'h0000);
      check($sformatf("reset_rd2_%0d", 15 - i), rd2, 16'h0000);
      check($sformatf("reset_dbg_%0d", i), dbg_data, 16'h0000);
    end

    // ALU write to R5: forwarded now, stored at the next edge.
    regWrite_in = 1'b1; rd_in = 4'd5; resultSrc_in = 2'b00; aluRes_in = 16'hBEEF;
    ra1 = 4'd5; ra2 = 4'd5; dbg_addr = 4'd5;
    #1;
    check("bypass_resultW", resultW, 16'hBEEF);
    check("bypass_rd1", rd1, 16'hBEEF);
    check("bypass_rd2_same_addr", rd2, 16'hBEEF);
    check("bypass_dbg_stale", dbg_data, 16'h0000);
    check("bypass_cnt_before", wr_count, 16'h0000);
    step();
    regWrite_in = 1'b0;
    #1;
    check("r5_dbg_after", dbg_data, 16'hBEEF);
    check("r5_rd1_stored", rd1, 16'hBEEF);
    check("r5_cnt", wr_count, 16'h0001);

    // A write to R0 is discarded and not counted.
    regWrite_in = 1'b1; rd_in = 4'd0; aluRes_in = 16'h1234; ra1 = 4'd0; dbg_addr = 4'd0;
    #1;
    check("r0_resultW", resultW, 16'h1234);
    check("r0_rd1_bypass_blocked", rd1, 16'h0000);
    step();
    regWrite_in = 1'b0;
    #1;
    check("r0_rd1_after", rd1, 16'h0000);
    check("r0_dbg_after", dbg_data, 16'h0000);
    check("r0_cnt", wr_count, 16'h0001);

    // Back-to-back writes to R3 (memory data, then PC+2). The last write wins.
    regWrite_in = 1'b1; rd_in = 4'd3; resultSrc_in = 2'b01; readData_in = 16'hA5A5;
    aluRes_in = 16'h1111; pc_plus2_in = 16'h0042; ra1 = 4'd3; ra2 = 4'd5; dbg_addr = 4'd3;
    #1;
    check("r3_mem_resultW", resultW, 16'hA5A5);
    check("r3_mem_rd1", rd1, 16'hA5A5);
    check("r3_rd2_other_reg", rd2, 16'hBEEF);
    step();
    resultSrc_in = 2'b10;
    #1;
    check("r3_pc_resultW", resultW, 16'h0042);
    check("r3_pc_rd1_bypass", rd1, 16'h0042);
    check("r3_dbg_first", dbg_data, 16'hA5A5);
    step();
    regWrite_in = 1'b0;
    #1;
    check("r3_dbg_last_wins", dbg_data, 16'h0042);
    check("r3_cnt", wr_count, 16'h0003);

    // Reserved select commits zero and still counts.
    regWrite_in = 1'b1; rd_in = 4'd4; resultSrc_in = 2'b00; aluRes_in = 16'h1111;
    ra1 = 4'd4; dbg_addr = 4'd4;
    step();
    resultSrc_in = 2'b11;
    #1;
    check("r4_rsvd_resultW", resultW, 16'h0000);
    check("r4_rsvd_rd1", rd1, 16'h0000);
    check("r4_dbg_prev", dbg_data, 16'h1111);
    step();
    regWrite_in = 1'b0;
    #1;
    check("r4_dbg_zero", dbg_data, 16'h0000);
    check("r4_cnt", wr_count, 16'h0005);

    // Reset together with a commit: reset dominates and forwarding is off.
    reset = 1'b1; regWrite_in = 1'b1; rd_in = 4'd7; resultSrc_in = 2'b00;
    aluRes_in = 16'h7777; ra1 = 4'd7; ra2 = 4'd5; dbg_addr = 4'd7;
    #1;
    check("rst_rd1_no_bypass", rd1, 16'h0000);
    check("rst_rd2_stored", rd2, 16'hBEEF);
    check("rst_resultW", resultW, 16'h7777);
    step();
    reset = 1'b0; regWrite_in = 1'b0;
    #1;
    check("rst_r7", dbg_data, 16'h0000);
    check("rst_rd2_cleared", rd2, 16'h0000);
    check("rst_cnt", wr_count, 16'h0000);

    // The first commit right after reset takes effect.
    regWrite_in = 1'b1;
    step();
    regWrite_in = 1'b0;
    #1;
    check("post_rst_r7", dbg_data, 16'h7777);
    check("post_rst_cnt", wr_count, 16'h0001);

    // Run wr_count up to FFFF, then wrap it with one more commit.
    regWrite_in = 1'b1; rd_in = 4'd1; aluRes_in = 16'h0ABC; dbg_addr = 4'd1; ra1 = 4'd1;
    repeat (65534) @(posedge clk);
    #1;
    regWrite_in = 1'b0;
    #1;
    check("cnt_ffff", wr_count, 16'hFFFF);
    check("r1_loop_val", dbg_data, 16'h0ABC);
    regWrite_in = 1'b1; aluRes_in = 16'hCAFE;
    step();
    regWrite_in = 1'b0;
    #1;
    check("cnt_wrap", wr_count, 16'h0000);
    check("r1_wrap_val", rd1, 16'hCAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
